// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
// State encoding, default sizes and the one-hot helper.
package mux_rr_arbiter_pkg;

  localparam int N_DEF     = 4;
  localparam int SEL_W_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [N_DEF-1:0] onehot(
    input logic [SEL_W_DEF-1:0] idx
  );
    logic [N_DEF-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating winner search: rotate mask past last_ptr,
// pick the lowest set bit, rotate the index back.
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [SEL_W-1:0] last_ptr,
  output logic             found,
  output logic [SEL_W-1:0] win
);

  logic [N-1:0] rot;
  int           off;

  // rotate, priority-encode, rotate back
  always_comb begin
    rot = '0;
    off = 0;
    for (int i = 0; i < N; i++) begin
      rot[i] = mask[(int'(last_ptr) + 1 + i) % N];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    found = |mask;
    win   = SEL_W'((int'(last_ptr) + 1 + off) % N);
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux select.
// Optional hold limit enabled by ARB_HOLD_LIMIT_EN.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] hold_cnt
);

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     others;
  logic [N-1:0]     mask;
  logic             found;
  logic [SEL_W-1:0] win;
  logic             limit;
  logic             keep;

  assign others = req & ~onehot(sel_q);
  assign mask   = (state_q == ST_BUSY) ? others : req;

`ifdef ARB_HOLD_LIMIT_EN
  assign limit = (cnt_q == CNT_W'(MAX_HOLD));
`else
  assign limit = 1'b0 & (cnt_q == CNT_W'(MAX_HOLD));
`endif

  assign keep = req[sel_q] && !(limit && (|others));

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .mask     (mask),
    .last_ptr (last_q),
    .found    (found),
    .win      (win)
  );

  // next state: grant, keep, hand off or go idle
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BUSY;
          gnt_d   = onehot(win);
          vld_d   = 1'b1;
          sel_d   = win;
          last_d  = win;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (keep) begin
          if (limit) begin
            cnt_d = CNT_W'(1);
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (found) begin
          gnt_d  = onehot(win);
          sel_d  = win;
          last_d = win;
          cnt_d  = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, owner, pointer and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      sel_q   <= '0;
      last_q  <= SEL_W'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = vld_q;
  assign sel       = sel_q;
  assign hold_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter.
// Vector table, hand sequences, per-cycle invariants.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] sel;
  logic [2:0] hold_cnt;

  logic [3:0] mux_i;
  logic       mux_y;

  int n_chk;
  int n_fail;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
    logic [2:0] cnt;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
    logic [2:0] cnt;
    string      name;
  } exp_t;

  vec_t tbl[22];
  exp_t sbq[$];

  mux_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .sel       (sel),
    .hold_cnt  (hold_cnt)
  );

  assign mux_i = 4'b1101;
  assign mux_y = mux_i[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(
    input logic       r,
    input logic [3:0] q,
    input logic [3:0] eg,
    input logic [1:0] es,
    input logic       ev,
    input logic [2:0] ec,
    input string      nm
  );
    exp_t e;
    @(negedge clk);
    rst = r;
    req = q;
    e.gnt  = eg;
    e.sel  = es;
    e.vld  = ev;
    e.cnt  = ec;
    e.name = nm;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({nm, "_sbq"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      chk({e.name, "_gnt"}, int'(gnt), int'(e.gnt));
      chk({e.name, "_sel"}, int'(sel), int'(e.sel));
      chk({e.name, "_vld"}, int'(gnt_valid), int'(e.vld));
      chk({e.name, "_cnt"}, int'(hold_cnt), int'(e.cnt));
    end
  endtask

  // invariants sampled away from the active edge
  always @(negedge clk) begin
    int idx;
    idx = 0;
    for (int k = 0; k < 4; k++) if (gnt[k]) idx = k;
    chk("inv_onehot", int'($onehot0(gnt)), 1);
    chk("inv_valid", int'(gnt_valid), int'(|gnt));
    if (gnt_valid) chk("inv_mux", int'(mux_y), int'(mux_i[idx]));
  end

  initial begin
    logic [3:0] eg;
    logic [2:0] ec;
    int         own;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    req    = 4'b0000;

    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 3'd1};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 3'd0};
    tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 3'd1};
    tbl[6]  = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, 3'd1};
    tbl[7]  = '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1, 3'd1};
    tbl[8]  = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1, 3'd1};
    tbl[9]  = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1, 3'd1};
    tbl[10] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 3'd2};
    tbl[11] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 3'd1};
    tbl[12] = '{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 3'd2};
    tbl[13] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 3'd1};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 3'd0};
    tbl[15] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 3'd1};
    tbl[16] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 3'd1};
    tbl[17] = '{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 3'd2};
    tbl[18] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 3'd1};
    tbl[19] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 3'd2};
    tbl[20] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 3'd1};
    tbl[21] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 3'd0};

    for (int v = 0; v < 22; v++) begin
      step(tbl[v].rst, tbl[v].req, tbl[v].gnt, tbl[v].sel,
           tbl[v].vld, tbl[v].cnt, $sformatf("vec%0d", v));
    end

    // contention between two steady requesters
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0, "hold_rst");
    for (int k = 0; k < 12; k++) begin
`ifdef ARB_HOLD_LIMIT_EN
      own = (k / 4) % 2;
      ec  = 3'((k % 4) + 1);
`else
      own = 0;
      ec  = (k < 7) ? 3'(k + 1) : 3'd7;
`endif
      eg = 4'b0001 << own;
      step(1'b0, 4'b0011, eg, 2'(own), 1'b1, ec,
           $sformatf("hold%0d", k));
    end

    // sole requester never loses the grant
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0, "solo_rst");
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_HOLD_LIMIT_EN
      ec = 3'((k % 4) + 1);
`else
      ec = (k < 7) ? 3'(k + 1) : 3'd7;
`endif
      step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, ec,
           $sformatf("solo%0d", k));
    end
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0, "solo_drop");

    // asynchronous reset between edges
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0, "ar_rst");
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 3'd1, "ar_gnt");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_now_gnt", int'(gnt), 0);
    chk("ar_now_sel", int'(sel), 0);
    chk("ar_now_vld", int'(gnt_valid), 0);
    chk("ar_now_cnt", int'(hold_cnt), 0);
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 3'd0, "ar_hold");
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 3'd1, "ar_first");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0, "ar_idle");

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
